// File: rtl/mem_result_reader.sv
// -----------------------------------------------------------------------------
// mem_result_reader
//
// Collects a frame of DEPTH result words from a producer into a small register
// file. It then drains the frame to a consumer over a valid/ready handshake.
// While the frame drains, the producer is locked out (Busy). Any write it
// attempts in that window is dropped and sets a sticky Overflow flag. A running
// modulo-2^DATA_WIDTH checksum covers the words the consumer accepts. FrameDone
// pulses for one cycle after the final word of a frame is taken.
//
// Ports
//   Clk        : single clock, all state changes on the rising edge
//   Reset      : synchronous, active-high
//   WrEn       : producer write strobe
//   WrData     : producer result word
//   Busy       : high while a frame drains (writes not accepted)
//   DataOut    : registered word presented to the consumer
//   Valid      : DataOut holds an unconsumed word
//   Ready      : consumer accepts DataOut when Valid && Ready at an edge
//   Last       : DataOut is the final word of the frame
//   Checksum   : sum of words accepted in the current / most recent frame
//   FrameDone  : one-cycle pulse after the final word is accepted
//   Overflow   : sticky, a write was attempted while Busy
// -----------------------------------------------------------------------------
module mem_result_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WrEn,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  Busy,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Valid,
    input  logic                  Ready,
    output logic                  Last,
    output logic [DATA_WIDTH-1:0] Checksum,
    output logic                  FrameDone,
    output logic                  Overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t nextState;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      rdPtrNext;

    logic wrAccept;
    logic rdAccept;
    logic frameFull;
    logic lastAccept;

    // Checksum accumulation; the carry out of the top bit is dropped.
    function automatic logic [DATA_WIDTH-1:0] wrapAdd(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // Next-state and handshake decode.
    always_comb begin
        nextState  = state;
        wrAccept   = (state == FILL) && WrEn;
        rdAccept   = (state == DRAIN) && Ready;
        frameFull  = wrAccept && (wrPtr == LAST_IDX);
        lastAccept = rdAccept && (rdPtr == LAST_IDX);
        rdPtrNext  = rdPtr + 1'b1;
        Busy       = (state == DRAIN);
        // In DRAIN there is always a word on DataOut. Valid therefore
        // follows the state directly.
        Valid      = (state == DRAIN);
        Last       = (state == DRAIN) && (rdPtr == LAST_IDX);

        case (state)
            FILL:    if (frameFull)  nextState = DRAIN;
            DRAIN:   if (lastAccept) nextState = FILL;
            default: nextState = FILL;
        endcase
    end

    // Storage is not reset. Writes are masked during Reset so that Reset
    // keeps priority over the producer.
    always_ff @(posedge Clk) begin
        if (!Reset && wrAccept) begin
            mem[wrPtr] <= WrData;
        end
    end

    // State, pointers, flags and the registered read word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= FILL;
            wrPtr     <= '0;
            rdPtr     <= '0;
            FrameDone <= 1'b0;
            Overflow  <= 1'b0;
            Checksum  <= '0;
            DataOut   <= '0;
        end else begin
            state     <= nextState;
            FrameDone <= lastAccept;

            if ((state == DRAIN) && WrEn) begin
                Overflow <= 1'b1;
            end

            if (wrAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end

            if (frameFull) begin
                // mem[0] is already settled unless the frame is a single word.
                // In that case the word being written now is the one to show.
                DataOut  <= (DEPTH == 1) ? WrData : mem[0];
                Checksum <= '0;
            end

            if (rdAccept) begin
                Checksum <= wrapAdd(Checksum, DataOut);
                if (lastAccept) begin
                    rdPtr <= '0;
                    wrPtr <= '0;
                end else begin
                    rdPtr   <= rdPtrNext;
                    DataOut <= mem[rdPtrNext];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_result_reader.sv
// -----------------------------------------------------------------------------
// tb_mem_result_reader
//
// Scoreboard bench for mem_result_reader (DATA_WIDTH=8, DEPTH=4). Each frame
// word pushes {last, data} onto a queue when the bench writes it. A negedge
// monitor pops and compares an entry for every accepted transfer.
// -----------------------------------------------------------------------------
module tb_mem_result_reader;

    logic       Clk;
    logic       Reset;
    logic       WrEn;
    logic [7:0] WrData;
    logic       Busy;
    logic [7:0] DataOut;
    logic       Valid;
    logic       Ready;
    logic       Last;
    logic [7:0] Checksum;
    logic       FrameDone;
    logic       Overflow;

    int checks   = 0;
    int failures = 0;
    int fdCount  = 0;

    logic [8:0] sbQueue [$];

    mem_result_reader #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .WrEn(WrEn),
        .WrData(WrData),
        .Busy(Busy),
        .DataOut(DataOut),
        .Valid(Valid),
        .Ready(Ready),
        .Last(Last),
        .Checksum(Checksum),
        .FrameDone(FrameDone),
        .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: one comparison pair per accepted word.
    always @(negedge Clk) begin
        if (!Reset && Valid && Ready) begin
            if (sbQueue.size() == 0) begin
                checkEq("unexpected_word", {24'd0, DataOut}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = sbQueue.pop_front();
                checkEq("sb_data", {24'd0, DataOut}, {24'd0, e[7:0]});
                checkEq("sb_last", {31'd0, Last}, {31'd0, e[8]});
            end
        end
    end

    always @(negedge Clk) begin
        if (FrameDone) fdCount++;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        WrEn  = 1'b0;
        step();
        Reset = 1'b0;
        sbQueue.delete();
        checkEq("rst_busy",      {31'd0, Busy},      32'd0);
        checkEq("rst_valid",     {31'd0, Valid},     32'd0);
        checkEq("rst_last",      {31'd0, Last},      32'd0);
        checkEq("rst_dataout",   {24'd0, DataOut},   32'd0);
        checkEq("rst_checksum",  {24'd0, Checksum},  32'd0);
        checkEq("rst_framedone", {31'd0, FrameDone}, 32'd0);
        checkEq("rst_overflow",  {31'd0, Overflow},  32'd0);
    endtask

    // Writes n words (n<=4). Scoreboard entries are pushed only when
    // push=1; word index 3 carries the last flag.
    task automatic writeWords(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3,
                              input int n, input bit push);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < n; i++) begin
            WrEn   = 1'b1;
            WrData = w[i];
            if (push) sbQueue.push_back({(i == 3), w[i]});
            step();
        end
        WrEn = 1'b0;
    endtask

    // Waits for FrameDone and returns the number of edges taken.
    // Running out of budget counts as a failure.
    task automatic waitFrameDone(input int bound, output int n);
        n = 0;
        while (!FrameDone && n < bound) begin
            step();
            n++;
        end
        checkEq("framedone_seen", {31'd0, FrameDone}, 32'd1);
    endtask

    int n;
    int fdBefore;

    initial begin
        Reset  = 1'b0;
        WrEn   = 1'b0;
        WrData = 8'h00;
        Ready  = 1'b1;
        step();
        doReset();

        // Basic frame, full-rate drain.
        writeWords(8'h10, 8'h20, 8'h30, 8'h40, 4, 1'b1);
        checkEq("entry_valid",    {31'd0, Valid},    32'd1);
        checkEq("entry_busy",     {31'd0, Busy},     32'd1);
        checkEq("entry_dataout",  {24'd0, DataOut},  32'h10);
        checkEq("entry_last",     {31'd0, Last},     32'd0);
        checkEq("entry_checksum", {24'd0, Checksum}, 32'd0);
        waitFrameDone(20, n);
        checkEq("drain_cycles", n, 32'd4);
        checkEq("f1_checksum",  {24'd0, Checksum}, 32'hA0);
        checkEq("f1_busy",      {31'd0, Busy},     32'd0);
        checkEq("f1_valid",     {31'd0, Valid},    32'd0);
        checkEq("f1_last",      {31'd0, Last},     32'd0);
        checkEq("f1_sb_empty",  sbQueue.size(),    32'd0);
        step();
        checkEq("fd_one_cycle",  {31'd0, FrameDone}, 32'd0);
        checkEq("dataout_held",  {24'd0, DataOut},   32'h40);
        checkEq("checksum_held", {24'd0, Checksum},  32'hA0);

        // Checksum wraps modulo 256.
        writeWords(8'hFF, 8'h02, 8'h80, 8'h81, 4, 1'b1);
        waitFrameDone(20, n);
        checkEq("wrap_checksum", {24'd0, Checksum}, 32'h02);
        step();

        // Consumer stall on the second word.
        writeWords(8'h01, 8'h02, 8'h03, 8'h04, 4, 1'b1);
        step();
        Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkEq("stall_data",  {24'd0, DataOut}, 32'h02);
            checkEq("stall_valid", {31'd0, Valid},   32'd1);
            checkEq("stall_last",  {31'd0, Last},    32'd0);
        end
        Ready = 1'b1;
        waitFrameDone(20, n);
        checkEq("stall_checksum", {24'd0, Checksum}, 32'h0A);
        checkEq("stall_sb_empty", sbQueue.size(),    32'd0);
        step();

        // Writes during DRAIN are dropped and set the sticky Overflow flag.
        writeWords(8'h11, 8'h22, 8'h33, 8'h44, 4, 1'b1);
        WrEn   = 1'b1;
        WrData = 8'h55;
        step();
        step();
        WrEn = 1'b0;
        checkEq("ovf_set", {31'd0, Overflow}, 32'd1);
        waitFrameDone(20, n);
        checkEq("ovf_checksum", {24'd0, Checksum}, 32'hAA);
        step();
        writeWords(8'h61, 8'h62, 8'h63, 8'h64, 4, 1'b1);
        checkEq("ovf_next_first", {24'd0, DataOut}, 32'h61);
        waitFrameDone(20, n);
        checkEq("ovf_sticky", {31'd0, Overflow}, 32'd1);
        step();

        // A write on the same edge as the last acceptance is dropped.
        doReset();
        writeWords(8'h05, 8'h06, 8'h07, 8'h08, 4, 1'b1);
        step();
        step();
        step();
        WrEn   = 1'b1;
        WrData = 8'h77;
        step();
        WrEn = 1'b0;
        checkEq("lastwr_framedone", {31'd0, FrameDone}, 32'd1);
        checkEq("lastwr_overflow",  {31'd0, Overflow},  32'd1);
        checkEq("lastwr_busy",      {31'd0, Busy},      32'd0);
        writeWords(8'h09, 8'h0A, 8'h0B, 8'h0C, 4, 1'b1);
        checkEq("lastwr_next_first", {24'd0, DataOut}, 32'h09);
        waitFrameDone(20, n);
        checkEq("lastwr_checksum", {24'd0, Checksum}, 32'h2A);
        step();

        // Reset during FILL abandons the partial frame.
        fdBefore = fdCount;
        writeWords(8'hEE, 8'hEF, 8'h00, 8'h00, 2, 1'b0);
        doReset();
        writeWords(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4, 1'b1);
        checkEq("rstfill_no_fd", fdCount, fdBefore);
        waitFrameDone(20, n);
        checkEq("rstfill_checksum", {24'd0, Checksum}, 32'h8A);
        step();
        checkEq("rstfill_fd_count", fdCount, fdBefore + 1);

        // Reset during DRAIN: no FrameDone is produced.
        fdBefore = fdCount;
        writeWords(8'h31, 8'h32, 8'h33, 8'h34, 4, 1'b1);
        step();
        doReset();
        step();
        step();
        checkEq("rstdrain_no_fd", fdCount, fdBefore);
        checkEq("rstdrain_busy",  {31'd0, Busy}, 32'd0);

        // Back-to-back frames: the second frame starts in the FrameDone cycle.
        writeWords(8'h01, 8'h01, 8'h01, 8'h01, 4, 1'b1);
        waitFrameDone(20, n);
        writeWords(8'h10, 8'h11, 8'h12, 8'h13, 4, 1'b1);
        checkEq("b2b_entry_checksum", {24'd0, Checksum}, 32'd0);
        waitFrameDone(20, n);
        checkEq("b2b_checksum", {24'd0, Checksum}, 32'h46);
        checkEq("b2b_sb_empty", sbQueue.size(),    32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_result_reader.md
MEM_RESULT_READER -- requirements
Module: mem_result_reader

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each result word.
REQ-002 Parameter: DEPTH, 4, number of result words per frame; power of two; pointer width = log2(DEPTH) (2 at default).
REQ-003 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: WrEn  input  1  producer write strobe (transfer-side WEB equivalent).
REQ-006 Port: WrData  input  DATA_WIDTH  producer result word (transfer-side DataInB equivalent).
REQ-007 Port: Busy  output  1  high while a frame is draining; producer writes are not accepted.
REQ-008 Port: DataOut  output  DATA_WIDTH  registered read word to consumer.
REQ-009 Port: Valid  output  1  DataOut holds an unconsumed word.
REQ-010 Port: Ready  input  1  consumer accepts DataOut when Valid&&Ready at a rising edge.
REQ-011 Port: Last  output  1  high with Valid when DataOut is word DEPTH-1 of the frame.
REQ-012 Port: Checksum  output  DATA_WIDTH  modulo-2^DATA_WIDTH sum of words accepted in the current or most recent frame.
REQ-013 Port: FrameDone  output  1  one-cycle pulse after the last word of a frame is accepted.
REQ-014 Port: Overflow  output  1  sticky flag: a write was attempted while Busy.

Function
REQ-015 Internal DEPTH x DATA_WIDTH register-file storage; write pointer WrPtr, read pointer RdPtr, both reset to 0.
REQ-016 Two states: FILL (Busy=0) and DRAIN (Busy=1); reset state FILL.
REQ-017 FILL: WrEn=1 at an edge stores WrData at mem[WrPtr], WrPtr increments, wrapping DEPTH-1 -> 0.
REQ-018 FILL -> DRAIN on the edge accepting the write with WrPtr=DEPTH-1; on the following cycle Valid=1, DataOut=mem[0], Last=0 (DEPTH>1), Checksum=0.
REQ-019 DRAIN: Valid&&Ready at an edge accepts DataOut, adds it to Checksum (carry discarded), increments RdPtr; the next cycle presents mem[RdPtr+1].
REQ-020 DRAIN with Valid=1, Ready=0: DataOut, Last, Valid, RdPtr held stable indefinitely.
REQ-021 Last=1 exactly when Valid=1 and RdPtr=DEPTH-1.
REQ-022 Acceptance of the Last word: next cycle state FILL, Valid=0, Last=0, RdPtr=0, WrPtr=0, FrameDone=1 for one cycle, Checksum holds final frame sum until the next DRAIN entry.
REQ-023 Throughput: with Ready tied high, one word accepted per cycle; DEPTH words drain in DEPTH cycles after DRAIN entry.
REQ-024 Write latency: a write accepted on edge N is readable in DRAIN no earlier than cycle N+1; a write and frame-to-DRAIN transition on the same edge store the word.
REQ-025 WrEn=1 in DRAIN: data discarded, storage and WrPtr unchanged, Overflow set to 1 and held until Reset.
REQ-026 WrEn=1 on the same edge the Last word is accepted: write discarded (state still DRAIN), Overflow set.
REQ-027 Ready ignored when Valid=0; no word accepted in FILL.
REQ-028 DataOut retains last presented value when Valid=0 (not driven to zero).

Reset
REQ-029 Reset=1 at an edge: state FILL, WrPtr=0, RdPtr=0, Valid=0, Last=0, Busy=0, FrameDone=0, Overflow=0, Checksum=0, DataOut=0; storage contents need not be cleared.
REQ-030 Reset mid-FILL or mid-DRAIN abandons the partial frame; no FrameDone pulse generated.
REQ-031 Reset has priority over WrEn and Ready on the same edge.

Verification
REQ-032 Fill 0x10,0x20,0x30,0x40 with Ready=1 -> DataOut 0x10,0x20,0x30,0x40 on consecutive cycles, Last only with 0x40, FrameDone pulse next cycle, Checksum=0xA0.
REQ-033 Fill 0xFF,0x02,0x80,0x81, Ready=1 -> Checksum=0x02 (wrap modulo 256).
REQ-034 Fill 1,2,3,4; Ready low 3 cycles at word 2 -> DataOut=0x02, Valid=1 held 3 cycles, then 0x03,0x04; order unchanged.
REQ-035 WrEn=1, WrData=0x55 during DRAIN -> Overflow=1 sticky, drained frame unchanged, next frame starts at mem[0].
REQ-036 Reset after 2 writes, then 4 writes 0xA1..0xA4 -> drain yields 0xA1..0xA4, no FrameDone before the full frame.
REQ-037 Two back-to-back frames with WrEn asserted the cycle after FrameDone -> second frame captured fully, Checksum reflects second frame only.
